// File: rtl/mac_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_drain_pkg
// Purpose  : Shared types and sizing constants for mac_result_drain.
//            The accumulator bound and index width are kept identical to
//            the values used by mac_nn.
// Contents : drain_state_t  - drain FSM state encoding
//            MAX_NUM_ACC    - upper bound on accumulator cells
//            DEF_SEL_W      - accumulator select width derived from the bound
//            sel_width()    - index width needed to address n cells
// Revision : 1.0  initial release
// ============================================================================
package mac_result_drain_pkg;

  localparam int MAX_NUM_ACC = 8;

  // Width needed to address n cells; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SEL_W = sel_width(MAX_NUM_ACC);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_drain_if
// Purpose  : Valid/ready result stream from mac_result_drain to the output
//            writeback stage.
// Signals  : out_data    - bank entry at out_idx
//            out_idx     - index of the current entry
//            out_written - entry captured at least once since clear/reset
//            out_valid   - stream valid
//            out_ready   - consumer ready
//            out_last    - final entry of the bank
// Modports : master (drain side), slave (consumer side)
// Revision : 1.0  initial release
// ============================================================================
interface mac_result_drain_if #(
  parameter int ACC_W = 16,
  parameter int SEL_W = 3
);

  logic [ACC_W-1:0] out_data;
  logic [SEL_W-1:0] out_idx;
  logic             out_written;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_written,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_written,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_drain
// Purpose  : Captures mac_nn results, tags each with the accumulator index
//            presented one cycle earlier, keeps the latest value per cell in
//            a shadow bank and streams the bank in index order on request.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            clear          - synchronous bank/flag clear (same as MAC clear)
//            do_mac_in      - a MAC operation is issued this cycle
//            acc_sel_in     - accumulator index issued to the MAC
//            acc_in         - MAC acc_out
//            acc_valid_in   - MAC valid_out
//            drain_start    - request to stream the bank
//            out_if         - result stream (master modport)
//            busy           - streaming in progress
//            done           - one-cycle pulse after the final handshake
//            err_overrun    - sticky: result arrived while streaming
//            err_orphan     - sticky: result arrived with no usable tag
// Revision : 1.0  initial release
// ============================================================================
module mac_result_drain
  import mac_result_drain_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int NUM_ACC = MAX_NUM_ACC,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             do_mac_in,
  input  wire logic [SEL_W-1:0] acc_sel_in,
  input  wire logic [ACC_W-1:0] acc_in,
  input  wire logic             acc_valid_in,
  input  wire logic             drain_start,
  mac_result_drain_if.master    out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overrun,
  output logic                  err_orphan
);

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;

  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_tag_q;
  logic             r_tag_vld;
  logic [ACC_W-1:0] r_bank [NUM_ACC];
  logic [NUM_ACC-1:0] r_written;
  logic             r_done;
  logic             r_err_overrun;
  logic             r_err_orphan;

  logic             w_busy;
  logic             w_last;
  logic             w_fire;
  logic             w_tag_ok;
  logic             w_capture;
  logic             w_orphan;
  logic             w_overrun;

  // --------------------------------------------------------------------------
  // Next-state and stream outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state == DRAIN);
    w_last      = w_busy && (int'(r_idx) == NUM_ACC - 1);
    w_fire      = w_busy && out_if.out_ready;
    w_tag_ok    = r_tag_vld && (int'(r_tag_q) < NUM_ACC);

    // A result pairs with the tag captured on the previous edge; anything
    // arriving while streaming is dropped so the bank stays frozen.
    w_capture   = acc_valid_in && !clear && !w_busy && w_tag_ok;
    w_orphan    = acc_valid_in && !clear && !w_busy && !w_tag_ok;
    w_overrun   = acc_valid_in && !clear && w_busy;

    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (drain_start)        w_state_nxt = DRAIN;
        DRAIN:   if (w_fire && w_last)   w_state_nxt = IDLE;
        default:                         w_state_nxt = IDLE;
      endcase
    end

    // Quiet outputs outside DRAIN keep the stream at zero in IDLE and reset.
    out_if.out_valid   = w_busy;
    out_if.out_idx     = r_idx;
    out_if.out_data    = w_busy ? r_bank[r_idx] : '0;
    out_if.out_written = w_busy && r_written[r_idx];
    out_if.out_last    = w_last;

    busy        = w_busy;
    done        = r_done;
    err_overrun = r_err_overrun;
    err_orphan  = r_err_orphan;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline, shadow bank, index counter and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_q       <= '0;
      r_tag_vld     <= 1'b0;
      r_idx         <= '0;
      r_written     <= '0;
      r_done        <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_orphan  <= 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_tag_q   <= acc_sel_in;
      r_tag_vld <= do_mac_in && !clear;
      r_done    <= 1'b0;

      if (clear) begin
        // An aborted stream ends here without a done pulse.
        r_idx         <= '0;
        r_written     <= '0;
        r_err_overrun <= 1'b0;
        r_err_orphan  <= 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
          r_bank[i] <= '0;
        end
      end else begin
        // Running sums: a later result for the same cell simply replaces it.
        if (w_capture) begin
          r_bank[r_tag_q]    <= acc_in;
          r_written[r_tag_q] <= 1'b1;
        end
        if (w_orphan) begin
          r_err_orphan <= 1'b1;
        end
        if (w_overrun) begin
          r_err_overrun <= 1'b1;
        end

        if (!w_busy && drain_start) begin
          r_idx <= '0;
        end else if (w_fire) begin
          if (w_last) begin
            r_idx  <= '0;
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_drain
// Purpose  : Directed self-checking bench for mac_result_drain.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_result_drain;

  localparam int ACC_W   = 16;
  localparam int NUM_ACC = 8;
  localparam int SEL_W   = 3;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             do_mac_in;
  logic [SEL_W-1:0] acc_sel_in;
  logic [ACC_W-1:0] acc_in;
  logic             acc_valid_in;
  logic             drain_start;
  logic             busy;
  logic             done;
  logic             err_overrun;
  logic             err_orphan;

  mac_result_drain_if #(.ACC_W(ACC_W), .SEL_W(SEL_W)) s_if ();

  mac_result_drain #(
    .ACC_W   (ACC_W),
    .NUM_ACC (NUM_ACC),
    .SEL_W   (SEL_W)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .do_mac_in    (do_mac_in),
    .acc_sel_in   (acc_sel_in),
    .acc_in       (acc_in),
    .acc_valid_in (acc_valid_in),
    .drain_start  (drain_start),
    .out_if       (s_if),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun),
    .err_orphan   (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ACC_W-1:0] exp_d [NUM_ACC];
  logic             exp_w [NUM_ACC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic dm, input logic [SEL_W-1:0] sel,
                      input logic av, input logic [ACC_W-1:0] d);
    do_mac_in    = dm;
    acc_sel_in   = sel;
    acc_valid_in = av;
    acc_in       = d;
    tick();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NUM_ACC; i++) begin
      exp_d[i] = '0;
      exp_w[i] = 1'b0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    clear_exp();
  endtask

  // Starts a drain (any capture inputs already set are applied on the same
  // edge), then checks every beat against exp_d/exp_w. ready is held low for
  // stall_n cycles when index stall_at is presented.
  task automatic drain_check(input string nm, input int stall_at, input int stall_n);
    int cycles;
    drain_start = 1'b1;
    tick();
    drain_start  = 1'b0;
    acc_valid_in = 1'b0;
    do_mac_in    = 1'b0;
    cycles = 0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (i == stall_at) begin
        s_if.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({nm, "_stall_idx"},  32'(s_if.out_idx),  32'(i));
          chk({nm, "_stall_data"}, 32'(s_if.out_data), 32'(exp_d[i]));
          tick();
          cycles++;
        end
        s_if.out_ready = 1'b1;
      end
      chk({nm, "_valid"}, 32'(s_if.out_valid),   32'd1);
      chk({nm, "_idx"},   32'(s_if.out_idx),     32'(i));
      chk({nm, "_data"},  32'(s_if.out_data),    32'(exp_d[i]));
      chk({nm, "_wr"},    32'(s_if.out_written), 32'(exp_w[i]));
      chk({nm, "_last"},  32'(s_if.out_last),    32'(i == NUM_ACC - 1));
      chk({nm, "_nodone"}, 32'(done),            32'd0);
      tick();
      cycles++;
    end
    chk({nm, "_done"},   32'(done),        32'd1);
    chk({nm, "_busy0"},  32'(busy),        32'd0);
    chk({nm, "_valid0"}, 32'(s_if.out_valid), 32'd0);
    chk({nm, "_cycles"}, 32'(cycles),      32'(NUM_ACC + stall_n));
    tick();
    chk({nm, "_done1"},  32'(done),        32'd0);
  endtask

  initial begin
    int k;
    rst          = 1'b1;
    clear        = 1'b0;
    do_mac_in    = 1'b0;
    acc_sel_in   = '0;
    acc_in       = '0;
    acc_valid_in = 1'b0;
    drain_start  = 1'b0;
    s_if.out_ready = 1'b1;
    clear_exp();
    tick();
    tick();

    // Reset state
    chk("rst_busy",    32'(busy),             32'd0);
    chk("rst_valid",   32'(s_if.out_valid),   32'd0);
    chk("rst_done",    32'(done),             32'd0);
    chk("rst_data",    32'(s_if.out_data),    32'd0);
    chk("rst_last",    32'(s_if.out_last),    32'd0);
    chk("rst_ovr",     32'(err_overrun),      32'd0);
    chk("rst_orph",    32'(err_orphan),       32'd0);
    rst = 1'b0;
    tick();

    // Basic capture: sel 0,1,2 then results 5,7,9 one cycle later
    step(1'b1, 3'd0, 1'b0, 16'd0);
    step(1'b1, 3'd1, 1'b1, 16'd5);
    step(1'b1, 3'd2, 1'b1, 16'd7);
    step(1'b0, 3'd0, 1'b1, 16'd9);
    idle();
    exp_d[0] = 16'd5; exp_w[0] = 1'b1;
    exp_d[1] = 16'd7; exp_w[1] = 1'b1;
    exp_d[2] = 16'd9; exp_w[2] = 1'b1;
    chk("basic_orph", 32'(err_orphan), 32'd0);
    drain_check("basic", -1, 0);

    // Backpressure at index 2 for 3 cycles
    drain_check("bp", 2, 3);

    // Overwrite sel 4, and a capture coincident with drain_start on sel 5
    step(1'b1, 3'd4, 1'b0, 16'h0000);
    step(1'b0, 3'd0, 1'b1, 16'h0010);
    step(1'b1, 3'd4, 1'b0, 16'h0000);
    step(1'b0, 3'd0, 1'b1, 16'h0030);
    step(1'b1, 3'd5, 1'b0, 16'h0000);
    do_mac_in    = 1'b0;
    acc_valid_in = 1'b1;
    acc_in       = 16'h0055;
    exp_d[4] = 16'h0030; exp_w[4] = 1'b1;
    exp_d[5] = 16'h0055; exp_w[5] = 1'b1;
    drain_check("ovw", -1, 0);
    chk("ovw_orph", 32'(err_orphan), 32'd0);

    // Overrun: result arrives during DRAIN
    drain_start = 1'b1;
    tick();
    drain_start  = 1'b0;
    acc_valid_in = 1'b1;
    acc_in       = 16'hFFFF;
    tick();
    acc_valid_in = 1'b0;
    chk("ovr_flag", 32'(err_overrun), 32'd1);
    chk("ovr_orph", 32'(err_orphan),  32'd0);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("ovr_done", 32'(done), 32'd1);
    tick();
    drain_check("ovr_bank", -1, 0);

    // Orphan: result with no preceding do_mac_in
    step(1'b0, 3'd3, 1'b1, 16'h1234);
    idle();
    chk("orph_flag", 32'(err_orphan),  32'd1);
    chk("orph_ovr",  32'(err_overrun), 32'd1);
    drain_check("orph_bank", -1, 0);

    // Both flags clear on clear
    do_clear();
    chk("clr_ovr",  32'(err_overrun), 32'd0);
    chk("clr_orph", 32'(err_orphan),  32'd0);

    // Clear mid-drain at index 3
    step(1'b1, 3'd1, 1'b0, 16'h0000);
    step(1'b0, 3'd0, 1'b1, 16'h0011);
    idle();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    tick();
    chk("cmd_idx3", 32'(s_if.out_idx), 32'd3);
    do_clear();
    chk("cmd_busy",  32'(busy),           32'd0);
    chk("cmd_valid", 32'(s_if.out_valid), 32'd0);
    chk("cmd_done",  32'(done),           32'd0);
    tick();
    chk("cmd_done2", 32'(done),           32'd0);
    drain_check("cmd_redrain", -1, 0);

    // Asynchronous reset mid-drain
    step(1'b1, 3'd6, 1'b0, 16'h0000);
    step(1'b0, 3'd0, 1'b1, 16'h0066);
    idle();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy",  32'(busy),             32'd0);
    chk("ar_valid", 32'(s_if.out_valid),   32'd0);
    chk("ar_idx",   32'(s_if.out_idx),     32'd0);
    chk("ar_data",  32'(s_if.out_data),    32'd0);
    chk("ar_wr",    32'(s_if.out_written), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    clear_exp();
    chk("ar_idle", 32'(busy), 32'd0);
    drain_check("ar_bank", -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
